// File: rtl/rv_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, ALU operation classes and datapath mux selects.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRd    = 4'd3,
    StMemWr    = 4'd4,
    StWbMem    = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StWbAlu    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StExecJalr = 4'd11,
    StTrap     = 4'd12
  } state_e;

  // Major opcodes, IR[6:0]
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALUOp classes, same meaning as in the single-cycle decoder
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_R      = 2'b10;
  localparam logic [1:0] ALU_OP_I      = 2'b11;

  localparam logic [1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JALR   = 2'b10;

  localparam logic [1:0] WB_SEL_ALUOUT = 2'b00;
  localparam logic [1:0] WB_SEL_MDR    = 2'b01;
  localparam logic [1:0] WB_SEL_PC4    = 2'b10;

  localparam logic [1:0] CAUSE_NONE        = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL     = 2'b01;
  localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'b10;

  // States that own the shared memory port
  function automatic logic is_mem_state(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Shared memory port between the control FSM (master) and memory (slave).
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles and flags the cycle in which the
// stall budget runs out. A MEM_TIMEOUT of 0 disables the timeout.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  output logic expired
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  // Expiry is taken in the stall cycle that would bring the count to MEM_TIMEOUT
  localparam logic [CntW-1:0] Limit = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  // Timeout fires only while still stalled, so a late mem_ready wins
  always_comb begin
    expired = (MEM_TIMEOUT != 0) && stall && (cnt_q == Limit);
  end

  // Any non-stalled cycle (completion or leaving the port) restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!stall || (MEM_TIMEOUT == 0)) begin
      cnt_q <= '0;
    end else if (cnt_q != Limit) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle RV32I core: walks each instruction
// through fetch/decode/execute/memory/writeback and drives datapath controls.
module multicycle_control
  import rv_mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master mem,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  output logic                 ir_write,
  output logic                 mdr_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic [1:0]           ALUOp,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_W-1:0]     retired,
  output logic [3:0]           state_o
);

  state_e             state_q;
  logic               trap_q;
  logic [1:0]         trap_cause_q;
  logic [CNT_W-1:0]   retired_q;
  logic               stall;
  logic               timeout;
  logic               retire;

  assign stall      = is_mem_state(state_q) && !mem.mem_ready;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;
  assign retired    = retired_q;
  assign state_o    = state_q;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .stall  (stall),
    .expired(timeout)
  );

  // Cycles in which an instruction completes
  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      StMemWr:                                     retire = mem.mem_ready;
      StWbMem, StWbAlu, StBranch, StJal, StExecJalr: retire = 1'b1;
      default:                                     retire = 1'b0;
    endcase
  end

  // State sequencing, sticky trap capture and retired-instruction count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
      retired_q    <= '0;
    end else begin
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      unique case (state_q)
        StFetch: begin
          if (mem.mem_ready) begin
            state_q <= StDecode;
          end else if (timeout) begin
            state_q      <= StTrap;
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_MEM_TIMEOUT;
          end
        end
        StDecode: begin
          case (opcode)
            OP_LOAD, OP_STORE: state_q <= StMemAddr;
            OP_R:              state_q <= StExecR;
            OP_IMM:            state_q <= StExecI;
            OP_BRANCH:         state_q <= StBranch;
            OP_JAL:            state_q <= StJal;
            OP_JALR:           state_q <= StExecJalr;
            default: begin
              state_q      <= StTrap;
              trap_q       <= 1'b1;
              trap_cause_q <= CAUSE_ILLEGAL;
            end
          endcase
        end
        // opcode[5] separates STORE (0100011) from LOAD (0000011)
        StMemAddr: state_q <= opcode[5] ? StMemWr : StMemRd;
        StMemRd: begin
          if (mem.mem_ready) begin
            state_q <= StWbMem;
          end else if (timeout) begin
            state_q      <= StTrap;
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_MEM_TIMEOUT;
          end
        end
        StMemWr: begin
          if (mem.mem_ready) begin
            state_q <= StFetch;
          end else if (timeout) begin
            state_q      <= StTrap;
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_MEM_TIMEOUT;
          end
        end
        StExecR, StExecI:                         state_q <= StWbAlu;
        StWbMem, StWbAlu, StBranch, StJal, StExecJalr: state_q <= StFetch;
        StTrap:                                   state_q <= StTrap;
        default: begin
          state_q      <= StTrap;
          trap_q       <= 1'b1;
          trap_cause_q <= CAUSE_ILLEGAL;
        end
      endcase
    end
  end

  // Moore decode of datapath controls; handshake-qualified strobes use mem_ready
  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_write    = 1'b0;
    mdr_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_PC4;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    ALUOp       = ALU_OP_ADD;
    reg_write   = 1'b0;
    wb_sel      = WB_SEL_ALUOUT;
    unique case (state_q)
      StFetch: begin
        mem.mem_req = 1'b1;
        ir_write    = mem.mem_ready;
        pc_write    = mem.mem_ready;
      end
      StDecode: begin
        alu_src_b = 1'b1;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 1'b1;
      end
      StMemRd: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        mdr_write   = mem.mem_ready;
      end
      StMemWr: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.iord    = 1'b1;
      end
      StWbMem: begin
        reg_write = 1'b1;
        wb_sel    = WB_SEL_MDR;
      end
      StExecR: begin
        alu_src_a = 1'b1;
        ALUOp     = ALU_OP_R;
      end
      StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = 1'b1;
        ALUOp     = ALU_OP_I;
      end
      StWbAlu: begin
        reg_write = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        ALUOp     = ALU_OP_BRANCH;
        pc_write  = branch_taken;
        pc_src    = PC_SRC_ALUOUT;
      end
      StJal: begin
        reg_write = 1'b1;
        wb_sel    = WB_SEL_PC4;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_ALUOUT;
      end
      StExecJalr: begin
        alu_src_a = 1'b1;
        alu_src_b = 1'b1;
        reg_write = 1'b1;
        wb_sel    = WB_SEL_PC4;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_JALR;
      end
      default: ;
    endcase
    // Reset kills every strobe at once so an aborted instruction writes nothing
    if (!rst_n) begin
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      mem.iord    = 1'b0;
      ir_write    = 1'b0;
      mdr_write   = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_SRC_PC4;
      alu_src_a   = 1'b0;
      alu_src_b   = 1'b0;
      ALUOp       = ALU_OP_ADD;
      reg_write   = 1'b0;
      wb_sel      = WB_SEL_ALUOUT;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with MEM_TIMEOUT=4. Inputs change
// just after the rising edge; outputs are sampled on the falling edge.
module tb_multicycle_control;
  import rv_mc_pkg::*;

  // Control vector layout: mem_req mem_we iord | ir_write mdr_write pc_write |
  // pc_src | alu_src_a alu_src_b | ALUOp | reg_write | wb_sel
  localparam logic [14:0] C_IDLE       = 15'b000_000_00_00_00_0_00;
  localparam logic [14:0] C_FETCH_WAIT = 15'b100_000_00_00_00_0_00;
  localparam logic [14:0] C_FETCH_GO   = 15'b100_101_00_00_00_0_00;
  localparam logic [14:0] C_DECODE     = 15'b000_000_00_01_00_0_00;
  localparam logic [14:0] C_MEM_ADDR   = 15'b000_000_00_11_00_0_00;
  localparam logic [14:0] C_RD_WAIT    = 15'b101_000_00_00_00_0_00;
  localparam logic [14:0] C_RD_GO      = 15'b101_010_00_00_00_0_00;
  localparam logic [14:0] C_WR         = 15'b111_000_00_00_00_0_00;
  localparam logic [14:0] C_WB_MEM     = 15'b000_000_00_00_00_1_01;
  localparam logic [14:0] C_EXEC_R     = 15'b000_000_00_10_10_0_00;
  localparam logic [14:0] C_EXEC_I     = 15'b000_000_00_11_11_0_00;
  localparam logic [14:0] C_WB_ALU     = 15'b000_000_00_00_00_1_00;
  localparam logic [14:0] C_BR_NT      = 15'b000_000_01_10_01_0_00;
  localparam logic [14:0] C_BR_T       = 15'b000_001_01_10_01_0_00;
  localparam logic [14:0] C_JAL        = 15'b000_001_01_00_00_1_10;
  localparam logic [14:0] C_JALR       = 15'b000_001_10_11_00_1_10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        ir_write, mdr_write, pc_write, alu_src_a, alu_src_b, reg_write, trap;
  logic [1:0]  pc_src, ALUOp, wb_sel, trap_cause;
  logic [31:0] retired;
  logic [3:0]  state_o;
  logic [14:0] ctl;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_ret = 32'd0;

  multicycle_control_if mem_bus ();

  multicycle_control #(
    .MEM_TIMEOUT(4),
    .CNT_W      (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (mem_bus),
    .opcode      (opcode),
    .branch_taken(branch_taken),
    .ir_write    (ir_write),
    .mdr_write   (mdr_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .ALUOp       (ALUOp),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .retired     (retired),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  assign ctl = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.iord, ir_write, mdr_write, pc_write,
                pc_src, alu_src_a, alu_src_b, ALUOp, reg_write, wb_sel};

  task automatic test_reset();
    rst_n = 1'b0;
    mem_bus.mem_ready = 1'b1;
    opcode = OP_R;
    branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if ({state_o, ctl, trap, trap_cause, retired} !== {StFetch, C_IDLE, 1'b0, 2'b00, 32'd0}) begin
      errors++;
      $display("FAIL reset: got state=%0d ctl=%b trap=%b cause=%b ret=%0d want 0/0/0/0/0",
               state_o, ctl, trap, trap_cause, retired);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ret = 32'd0;
  endtask

  task automatic test_rtype();
    state_e      st [4];
    logic [14:0] cv [4];
    st = '{StFetch, StDecode, StExecR, StWbAlu};
    cv = '{C_FETCH_GO, C_DECODE, C_EXEC_R, C_WB_ALU};
    mem_bus.mem_ready = 1'b1;
    opcode = OP_R;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({state_o, ctl} !== {st[i], cv[i]}) begin
        errors++;
        $display("FAIL rtype c%0d: got state=%0d ctl=%b want state=%0d ctl=%b",
                 i, state_o, ctl, st[i], cv[i]);
      end
      @(posedge clk); #1;
    end
    exp_ret++;
    checks++;
    if ({state_o, retired} !== {StFetch, exp_ret}) begin
      errors++;
      $display("FAIL rtype retire: got state=%0d ret=%0d want 0/%0d", state_o, retired, exp_ret);
    end
  endtask

  task automatic test_load_stall();
    state_e      st [8];
    logic [14:0] cv [8];
    logic        rdy [8];
    st  = '{StFetch, StDecode, StMemAddr, StMemRd, StMemRd, StMemRd, StMemRd, StWbMem};
    cv  = '{C_FETCH_GO, C_DECODE, C_MEM_ADDR, C_RD_WAIT, C_RD_WAIT, C_RD_WAIT, C_RD_GO,
            C_WB_MEM};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = OP_LOAD;
    for (int i = 0; i < 8; i++) begin
      mem_bus.mem_ready = rdy[i];
      @(negedge clk);
      checks++;
      if ({state_o, ctl} !== {st[i], cv[i]}) begin
        errors++;
        $display("FAIL load c%0d: got state=%0d ctl=%b want state=%0d ctl=%b",
                 i, state_o, ctl, st[i], cv[i]);
      end
      @(posedge clk); #1;
    end
    exp_ret++;
    checks++;
    if ({state_o, retired, trap} !== {StFetch, exp_ret, 1'b0}) begin
      errors++;
      $display("FAIL load retire: got state=%0d ret=%0d trap=%b want 0/%0d/0",
               state_o, retired, trap, exp_ret);
    end
  endtask

  task automatic test_store();
    state_e      st [5];
    logic [14:0] cv [5];
    logic        rdy [5];
    st  = '{StFetch, StDecode, StMemAddr, StMemWr, StMemWr};
    cv  = '{C_FETCH_GO, C_DECODE, C_MEM_ADDR, C_WR, C_WR};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    opcode = OP_STORE;
    for (int i = 0; i < 5; i++) begin
      mem_bus.mem_ready = rdy[i];
      @(negedge clk);
      checks++;
      if ({state_o, ctl} !== {st[i], cv[i]}) begin
        errors++;
        $display("FAIL store c%0d: got state=%0d ctl=%b want state=%0d ctl=%b",
                 i, state_o, ctl, st[i], cv[i]);
      end
      @(posedge clk); #1;
    end
    exp_ret++;
    checks++;
    if ({state_o, retired} !== {StFetch, exp_ret}) begin
      errors++;
      $display("FAIL store retire: got state=%0d ret=%0d want 0/%0d", state_o, retired, exp_ret);
    end
  endtask

  task automatic test_branch();
    state_e      st [3];
    logic [14:0] cv [3];
    st = '{StFetch, StDecode, StBranch};
    opcode = OP_BRANCH;
    mem_bus.mem_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      branch_taken = (t == 1);
      cv = '{C_FETCH_GO, C_DECODE, (t == 1) ? C_BR_T : C_BR_NT};
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checks++;
        if ({state_o, ctl} !== {st[i], cv[i]}) begin
          errors++;
          $display("FAIL branch t%0d c%0d: got state=%0d ctl=%b want state=%0d ctl=%b",
                   t, i, state_o, ctl, st[i], cv[i]);
        end
        @(posedge clk); #1;
      end
      exp_ret++;
      checks++;
      if ({state_o, retired} !== {StFetch, exp_ret}) begin
        errors++;
        $display("FAIL branch t%0d retire: got state=%0d ret=%0d want 0/%0d",
                 t, state_o, retired, exp_ret);
      end
    end
  endtask

  task automatic test_jumps();
    state_e      st [3];
    logic [14:0] cv [3];
    mem_bus.mem_ready = 1'b1;
    branch_taken = 1'b0;
    for (int j = 0; j < 2; j++) begin
      opcode = (j == 0) ? OP_JAL : OP_JALR;
      st = '{StFetch, StDecode, (j == 0) ? StJal : StExecJalr};
      cv = '{C_FETCH_GO, C_DECODE, (j == 0) ? C_JAL : C_JALR};
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checks++;
        if ({state_o, ctl} !== {st[i], cv[i]}) begin
          errors++;
          $display("FAIL jump j%0d c%0d: got state=%0d ctl=%b want state=%0d ctl=%b",
                   j, i, state_o, ctl, st[i], cv[i]);
        end
        @(posedge clk); #1;
      end
      exp_ret++;
      checks++;
      if ({state_o, retired} !== {StFetch, exp_ret}) begin
        errors++;
        $display("FAIL jump j%0d retire: got state=%0d ret=%0d want 0/%0d",
                 j, state_o, retired, exp_ret);
      end
    end
  endtask

  // mem_ready lands in the 4th wait cycle of FETCH: the access must complete
  task automatic test_timeout_race();
    state_e      st [7];
    logic [14:0] cv [7];
    logic        rdy [7];
    st  = '{StFetch, StFetch, StFetch, StFetch, StDecode, StExecI, StWbAlu};
    cv  = '{C_FETCH_WAIT, C_FETCH_WAIT, C_FETCH_WAIT, C_FETCH_GO, C_DECODE, C_EXEC_I, C_WB_ALU};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    opcode = OP_IMM;
    for (int i = 0; i < 7; i++) begin
      mem_bus.mem_ready = rdy[i];
      @(negedge clk);
      checks++;
      if ({state_o, ctl, trap} !== {st[i], cv[i], 1'b0}) begin
        errors++;
        $display("FAIL race c%0d: got state=%0d ctl=%b trap=%b want state=%0d ctl=%b trap=0",
                 i, state_o, ctl, trap, st[i], cv[i]);
      end
      @(posedge clk); #1;
    end
    exp_ret++;
    checks++;
    if ({state_o, retired, trap_cause} !== {StFetch, exp_ret, 2'b00}) begin
      errors++;
      $display("FAIL race retire: got state=%0d ret=%0d cause=%b want 0/%0d/00",
               state_o, retired, trap_cause, exp_ret);
    end
  endtask

  // Reset in the middle of a stalled load read must abort it immediately
  task automatic test_reset_mid();
    opcode = OP_LOAD;
    mem_bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({state_o, ctl} !== {StMemRd, C_RD_WAIT}) begin
      errors++;
      $display("FAIL midreset pre: got state=%0d ctl=%b want state=%0d ctl=%b",
               state_o, ctl, StMemRd, C_RD_WAIT);
    end
    #1;
    rst_n = 1'b0;
    mem_bus.mem_ready = 1'b1;
    #1;
    checks++;
    if ({state_o, ctl, retired} !== {StFetch, C_IDLE, 32'd0}) begin
      errors++;
      $display("FAIL midreset: got state=%0d ctl=%b ret=%0d want 0/0/0", state_o, ctl, retired);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ret = 32'd0;
  endtask

  task automatic test_illegal();
    mem_bus.mem_ready = 1'b1;
    opcode = 7'b1111111;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      mem_bus.mem_ready = i[0];
      branch_taken = ~i[0];
      @(negedge clk);
      checks++;
      if ({state_o, ctl, trap, trap_cause, retired} !== {StTrap, C_IDLE, 1'b1, 2'b01, exp_ret})
      begin
        errors++;
        $display("FAIL illegal c%0d: got state=%0d ctl=%b trap=%b cause=%b ret=%0d want %0d/0/1/01/%0d",
                 i, state_o, ctl, trap, trap_cause, retired, StTrap, exp_ret);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state_o, trap, trap_cause} !== {StFetch, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL illegal reset: got state=%0d trap=%b cause=%b want 0/0/00",
               state_o, trap, trap_cause);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ret = 32'd0;
  endtask

  task automatic test_timeout();
    opcode = OP_R;
    mem_bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({state_o, ctl, trap} !== {StFetch, C_FETCH_WAIT, 1'b0}) begin
        errors++;
        $display("FAIL timeout wait c%0d: got state=%0d ctl=%b trap=%b want 0/%b/0",
                 i, state_o, ctl, trap, C_FETCH_WAIT);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({state_o, ctl, trap, trap_cause} !== {StTrap, C_IDLE, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL timeout trap: got state=%0d ctl=%b trap=%b cause=%b want %0d/0/1/10",
               state_o, ctl, trap, trap_cause, StTrap);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ret = 32'd0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_stall();
    test_store();
    test_branch();
    test_jumps();
    test_timeout_race();
    test_reset_mid();
    test_illegal();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
